// File: rtl/inference_scheduler.sv
// inference_scheduler
//
// Sequences handwritten-digit inference between the canvas writer, the two
// shared canvas/input block RAMs and the neural network.
//   - Forwards accepted canvas writes to both RAMs one cycle later.
//   - Sweeps zeros across the whole memory on a clear request.
//   - Pulses nn_start once drawing has gone quiet (or on start_req, see below).
//   - Holds the last valid prediction for the display (4'hF = none).
//
// Build option:
//   MANUAL_START_EN - when defined, DIRTY -> START happens only on start_req and
//                     no quiet counter is built; start_req during RUN marks the
//                     running result stale. When undefined, a QUIET_CYCLES
//                     timeout starts inference and start_req is ignored.
//
// Ports:
//   clk            system clock
//   rst            synchronous, active-low reset
//   draw_we/addr/data  canvas write request
//   clear_req      single-cycle clear request
//   start_req      single-cycle manual start (MANUAL_START_EN only)
//   mem_we/addr/data   registered write port to both RAMs
//   nn_start       single-cycle inference start
//   nn_done        single-cycle inference complete, nn_result valid with it
//   predict_number held prediction
//   busy           high in START, RUN or CLEAR

module inference_scheduler #(
    parameter int unsigned MEM_DEPTH    = 784,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned QUIET_CYCLES = 2500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              draw_we,
    input  logic [ADDR_W-1:0] draw_addr,
    input  logic              draw_data,
    input  logic              clear_req,
    input  logic              start_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_data,
    output logic              nn_start,
    input  logic              nn_done,
    input  logic [3:0]        nn_result,
    output logic [3:0]        predict_number,
    output logic              busy
);

    localparam logic [ADDR_W:0]   DepthExt = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(MEM_DEPTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StDirty,
        StStart,
        StRun,
        StClear
    } state_e;

    state_e            state_q, state_d;
    logic              stale_q, stale_d;
    logic              pend_q, pend_d;
    logic [3:0]        predict_q, predict_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_data_q, mem_data_d;

    logic addr_ok;
    logic clear_now;
    logic wr_ok;
    logic start_go;
    logic stale_evt;
    logic load_cnt;
    logic enter_clr;

    assign addr_ok   = ({1'b0, draw_addr} < DepthExt);
    // A clear that will be acted on (or latched in START) wins over a same-cycle write.
    assign clear_now = clear_req && (state_q inside {StIdle, StDirty, StStart});
    assign wr_ok     = draw_we && addr_ok && (state_q != StClear) && !clear_now;

`ifdef MANUAL_START_EN
    logic unused_load;

    assign start_go    = start_req;
    assign stale_evt   = wr_ok || start_req;
    assign unused_load = load_cnt;
`else
    localparam int unsigned    CntW      = (QUIET_CYCLES > 0) ? $clog2(QUIET_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] CntReload = CntW'(QUIET_CYCLES);

    logic [CntW-1:0] cnt_q;
    logic            unused_start;

    // Start when this cycle's decrement brings the counter to zero; a write reloads instead.
    assign start_go     = !wr_ok && (cnt_q <= CntW'(1));
    assign stale_evt    = wr_ok;
    assign unused_start = start_req;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load_cnt) begin
            cnt_q <= CntReload;
        end else if ((state_q == StDirty) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CntW'(1);
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        stale_d    = stale_q;
        pend_d     = pend_q;
        predict_d  = predict_q;
        load_cnt   = 1'b0;
        enter_clr  = 1'b0;
        mem_we_d   = wr_ok;
        mem_addr_d = wr_ok ? draw_addr : mem_addr_q;
        mem_data_d = wr_ok ? draw_data : mem_data_q;

        case (state_q)
            StIdle: begin
                if (clear_req) begin
                    enter_clr = 1'b1;
                end else if (wr_ok) begin
                    state_d  = StDirty;
                    load_cnt = 1'b1;
                end
            end
            StDirty: begin
                if (clear_req) begin
                    enter_clr = 1'b1;
                end else begin
                    load_cnt = wr_ok;
                    if (start_go) begin
                        state_d = StStart;
                    end
                end
            end
            StStart: begin
                // The start pulse always goes out; a clear here waits for nn_done.
                state_d = StRun;
                if (clear_req) begin
                    pend_d = 1'b1;
                end
            end
            StRun: begin
                if (stale_evt) begin
                    stale_d = 1'b1;
                end
                if (clear_req) begin
                    pend_d = 1'b1;
                end
                if (nn_done) begin
                    if (pend_q || clear_req) begin
                        enter_clr = 1'b1;
                    end else if (stale_q || stale_evt) begin
                        state_d  = StDirty;
                        load_cnt = 1'b1;
                        stale_d  = 1'b0;
                    end else begin
                        predict_d = nn_result;
                        state_d   = StIdle;
                    end
                end
            end
            StClear: begin
                mem_data_d = 1'b0;
                if (mem_addr_q == LastAddr) begin
                    mem_we_d   = 1'b0;
                    mem_addr_d = mem_addr_q;
                    state_d    = StIdle;
                    predict_d  = 4'hF;
                    stale_d    = 1'b0;
                    pend_d     = 1'b0;
                end else begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // First sweep write is issued on the cycle the FSM enters CLEAR.
        if (enter_clr) begin
            state_d    = StClear;
            mem_we_d   = 1'b1;
            mem_addr_d = '0;
            mem_data_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            stale_q    <= 1'b0;
            pend_q     <= 1'b0;
            predict_q  <= 4'hF;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            stale_q    <= stale_d;
            pend_q     <= pend_d;
            predict_q  <= predict_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_data       = mem_data_q;
    assign nn_start       = (state_q == StStart);
    assign busy           = (state_q inside {StStart, StRun, StClear});
    assign predict_number = predict_q;

endmodule
